// File: rtl/stream_arbiter_pkg.sv
// Shared types and helpers for the stream arbiter family.
package stream_arbiter_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_e;

  localparam int MAX_STREAMS = 32;

  // First set bit at or after ptr, wrapping; mask bits above the live stream count must be zero.
  function automatic int rr_pick(input logic [MAX_STREAMS-1:0] mask, input int ptr);
    logic [4:0] idx;
    rr_pick = ptr;
    for (int i = MAX_STREAMS - 1; i >= 0; i--) begin
      idx = 5'(ptr + i);
      if (mask[idx]) rr_pick = int'(idx);
    end
  endfunction

endpackage

// File: rtl/stream_arbiter_pick.sv
// Combinational winner selection: starved streams first, otherwise highest QoS; ties go round-robin.
module stream_arbiter_pick
  import stream_arbiter_pkg::*;
#(
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
  parameter int AGE_WIDTH    = 3
) (
  input  logic [STREAM_COUNT-1:0] valid,
  input  logic [T_QOS__WIDTH-1:0] qos [STREAM_COUNT],
  input  logic [AGE_WIDTH-1:0]    age [STREAM_COUNT],
  input  logic [T_ID___WIDTH-1:0] rr_ptr,
  output logic [T_ID___WIDTH-1:0] winner,
  output logic                    any_valid
);

  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  logic [STREAM_COUNT-1:0] starved;
  logic [STREAM_COUNT-1:0] top_qos;
  logic [STREAM_COUNT-1:0] cand;
  logic [T_QOS__WIDTH-1:0] max_qos;

  always_comb begin
    starved = '0;
    top_qos = '0;
    max_qos = '0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      starved[i] = valid[i] && (age[i] == AGE_MAX);
      if (valid[i] && (qos[i] > max_qos)) max_qos = qos[i];
    end
    for (int i = 0; i < STREAM_COUNT; i++) begin
      top_qos[i] = valid[i] && (qos[i] == max_qos);
    end
    // A starved stream overrides QoS entirely.
    cand      = (|starved) ? starved : top_qos;
    winner    = T_ID___WIDTH'(rr_pick(MAX_STREAMS'(cand), int'(rr_ptr)));
    any_valid = |valid;
  end

endmodule

// File: rtl/stream_arbiter_aging.sv
// Packet-granular QoS stream arbiter with per-stream aging; the granted stream is passed through combinationally.
module stream_arbiter_aging
  import stream_arbiter_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
  parameter int AGE_WIDTH    = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i  [STREAM_COUNT],
  input  logic [T_QOS__WIDTH-1:0] s_qos_i   [STREAM_COUNT],
  input  logic [STREAM_COUNT-1:0] s_last_i,
  input  logic [STREAM_COUNT-1:0] s_valid_i,
  output logic [STREAM_COUNT-1:0] s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_QOS__WIDTH-1:0] m_qos_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  arb_state_e              state;
  logic [T_ID___WIDTH-1:0] grant_id;
  logic [T_ID___WIDTH-1:0] rr_ptr;
  logic [T_ID___WIDTH-1:0] winner;
  logic [AGE_WIDTH-1:0]    age [STREAM_COUNT];
  logic                    any_valid;

  stream_arbiter_pick #(
    .T_QOS__WIDTH(T_QOS__WIDTH),
    .STREAM_COUNT(STREAM_COUNT),
    .T_ID___WIDTH(T_ID___WIDTH),
    .AGE_WIDTH   (AGE_WIDTH)
  ) u_pick (
    .valid    (s_valid_i),
    .qos      (s_qos_i),
    .age      (age),
    .rr_ptr   (rr_ptr),
    .winner   (winner),
    .any_valid(any_valid)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      for (int i = 0; i < STREAM_COUNT; i++) age[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state    <= BURST;
            grant_id <= winner;
            rr_ptr   <= (winner == T_ID___WIDTH'(STREAM_COUNT - 1)) ? '0 : winner + T_ID___WIDTH'(1);
            // Losers that were competing get older; idle streams keep their age.
            for (int i = 0; i < STREAM_COUNT; i++) begin
              if (T_ID___WIDTH'(i) == winner) age[i] <= '0;
              else if (s_valid_i[i] && (age[i] != AGE_MAX)) age[i] <= age[i] + AGE_WIDTH'(1);
            end
          end
        end
        BURST: begin
          if (m_valid_o && m_ready_i && m_last_o) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready_o = '0;
    m_valid_o = 1'b0;
    m_data_o  = '0;
    m_qos_o   = '0;
    m_last_o  = 1'b0;
    m_id_o    = '0;
    if (state == BURST) begin
      m_valid_o           = s_valid_i[grant_id];
      m_data_o            = s_data_i[grant_id];
      m_qos_o             = s_qos_i[grant_id];
      m_last_o            = s_last_i[grant_id];
      m_id_o              = grant_id;
      s_ready_o[grant_id] = m_ready_i;
    end
  end

  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_n) $onehot0(s_ready_o));
  a_idle_no_valid: assert property (@(posedge clk_i) disable iff (!rst_n) (state == IDLE) |-> !m_valid_o);

endmodule

// File: tb/tb_stream_arbiter_aging.sv
// Bench for stream_arbiter_aging: directed scenarios plus random traffic against a behavioural reference.
module tb_stream_arbiter_aging;

  localparam int NS = 2, DW = 8, QW = 4, AW = 3, IW = 1;
  localparam int AGE_MAX = (1 << AW) - 1;
  localparam int OW = 1 + 1 + IW + DW + QW + NS;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data_i [NS];
  logic [QW-1:0] s_qos_i  [NS];
  logic [NS-1:0] s_last_i, s_valid_i, s_ready_o;
  logic [DW-1:0] m_data_o;
  logic [QW-1:0] m_qos_o;
  logic [IW-1:0] m_id_o;
  logic          m_last_o, m_valid_o, m_ready_i;
  logic [OW-1:0] obs;

  int total = 0, bad = 0;

  // reference model state
  int r_age [NS];
  int r_rr, r_gid;
  bit r_busy;

  // source generators
  int left [NS], pk [NS], plen [NS], hold [NS], seq [NS];
  logic [QW-1:0] pq [NS];
  bit rnd;

  always #5 clk_i = ~clk_i;

  assign obs = {m_valid_o, m_last_o, m_id_o, m_data_o, m_qos_o, s_ready_o};

  stream_arbiter_aging #(
    .T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(NS), .T_ID___WIDTH(IW), .AGE_WIDTH(AW)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .s_data_i(s_data_i), .s_qos_i(s_qos_i), .s_last_i(s_last_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_qos_o(m_qos_o), .m_id_o(m_id_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i)
  );

  task automatic ref_reset();
    for (int i = 0; i < NS; i++) r_age[i] = 0;
    r_rr = 0; r_gid = 0; r_busy = 0;
  endtask

  // Starved streams first, else highest QoS; scan from the round-robin pointer.
  function automatic int ref_winner();
    bit starved = 0;
    int best = -1;
    for (int i = 0; i < NS; i++) begin
      if (s_valid_i[i] && r_age[i] == AGE_MAX) starved = 1;
      if (s_valid_i[i] && int'(s_qos_i[i]) > best) best = int'(s_qos_i[i]);
    end
    for (int k = 0; k < NS; k++) begin
      int j = (r_rr + k) % NS;
      if (s_valid_i[j] && (starved ? (r_age[j] == AGE_MAX) : (int'(s_qos_i[j]) == best))) return j;
    end
    return -1;
  endfunction

  task automatic ref_clock();
    int w;
    if (!r_busy) begin
      w = ref_winner();
      if (w >= 0) begin
        for (int i = 0; i < NS; i++) begin
          if (i == w) r_age[i] = 0;
          else if (s_valid_i[i]) r_age[i] = (r_age[i] < AGE_MAX) ? r_age[i] + 1 : AGE_MAX;
        end
        r_rr = (w + 1) % NS; r_gid = w; r_busy = 1;
      end
    end else if (s_valid_i[r_gid] && m_ready_i && s_last_i[r_gid]) begin
      r_busy = 0;
    end
  endtask

  function automatic logic [OW-1:0] ref_out();
    logic [NS-1:0] rdy;
    rdy = '0;
    if (!r_busy) return '0;
    rdy[r_gid] = m_ready_i;
    return {s_valid_i[r_gid], s_last_i[r_gid], IW'(r_gid), s_data_i[r_gid], s_qos_i[r_gid], rdy};
  endfunction

  task automatic src_set(input int i, input int n, input int len, input int q);
    pk[i] = n; plen[i] = len; pq[i] = QW'(q); left[i] = 0; hold[i] = 0;
    s_valid_i[i] = 1'b0; s_last_i[i] = 1'b0;
  endtask

  // Retire transferred beats and present new ones; data is the per-stream beat sequence number.
  task automatic src_advance(input logic [NS-1:0] xf);
    for (int i = 0; i < NS; i++) begin
      if (xf[i]) begin
        if (left[i] > 0) left[i]--;
        seq[i]++;
        s_valid_i[i] = 1'b0;
      end
      if (!s_valid_i[i]) begin
        if (hold[i] > 0) hold[i]--;
        else begin
          if (left[i] == 0 && (rnd || pk[i] > 0)) begin
            left[i] = rnd ? int'($urandom_range(1, 4)) : plen[i];
            if (rnd) pq[i] = QW'($urandom_range(0, 15));
            else pk[i]--;
          end
          if (left[i] > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
            if (rnd && $urandom_range(0, 7) == 0) pq[i] = QW'($urandom_range(0, 15));
            s_data_i[i]  = DW'(seq[i]);
            s_last_i[i]  = (left[i] == 1);
            s_qos_i[i]   = pq[i];
            s_valid_i[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic clk_step();
    logic [NS-1:0] xf;
    xf = '0;
    if (r_busy) xf[r_gid] = s_valid_i[r_gid] & m_ready_i;
    ref_clock();
    @(posedge clk_i);
    #1;
    src_advance(xf);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rnd = 0; m_ready_i = 1'b0;
    for (int i = 0; i < NS; i++) begin
      src_set(i, 0, 1, 0);
      s_data_i[i] = '0; s_qos_i[i] = '0; seq[i] = i * 64;
    end
    ref_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rnd = 0;
    ref_reset();
    for (int i = 0; i < NS; i++) begin
      src_set(i, 0, 1, 0);
      seq[i] = i * 64;
      s_valid_i[i] = 1'b1; s_last_i[i] = 1'b1; s_qos_i[i] = 4'd3; s_data_i[i] = DW'(8'hA0 + i);
    end
    m_ready_i = 1'b1;
    #3; total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_out got=%h exp=0", obs); end
    repeat (2) @(posedge clk_i);
    #1; total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_hold got=%h exp=0", obs); end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2; total++;
      if (obs !== ref_out()) begin bad++; $display("FAIL reset_release cyc=%0d got=%h exp=%h", c, obs, ref_out()); end
      clk_step();
    end
  endtask

  task automatic test_priority();
    bit exp_v [9] = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
    int exp_id [9] = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
    do_reset();
    m_ready_i = 1'b1;
    src_set(0, 1, 3, 2); src_set(1, 1, 3, 5);
    src_advance('0);
    for (int c = 0; c < 9; c++) begin
      #2; total += 2;
      if (obs !== ref_out()) begin bad++; $display("FAIL prio_model cyc=%0d got=%h exp=%h", c, obs, ref_out()); end
      if (m_valid_o !== exp_v[c] || (exp_v[c] && int'(m_id_o) != exp_id[c])) begin
        bad++; $display("FAIL prio_seq cyc=%0d got v=%b id=%0d exp v=%b id=%0d", c, m_valid_o, m_id_o, exp_v[c], exp_id[c]);
      end
      clk_step();
    end
  endtask

  task automatic test_round_robin();
    bit exp_v [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int exp_id [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    do_reset();
    m_ready_i = 1'b1;
    src_set(0, 4, 1, 3); src_set(1, 4, 1, 3);
    src_advance('0);
    for (int c = 0; c < 8; c++) begin
      #2; total += 2;
      if (obs !== ref_out()) begin bad++; $display("FAIL rr_model cyc=%0d got=%h exp=%h", c, obs, ref_out()); end
      if (m_valid_o !== exp_v[c] || (exp_v[c] && int'(m_id_o) != exp_id[c])) begin
        bad++; $display("FAIL rr_seq cyc=%0d got v=%b id=%0d exp v=%b id=%0d", c, m_valid_o, m_id_o, exp_v[c], exp_id[c]);
      end
      clk_step();
    end
  endtask

  task automatic test_starvation();
    int grants [$];
    int exp_g [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    do_reset();
    m_ready_i = 1'b1;
    src_set(0, 20, 1, 15); src_set(1, 20, 1, 0);
    src_advance('0);
    for (int c = 0; c < 18; c++) begin
      #2; total++;
      if (obs !== ref_out()) begin bad++; $display("FAIL starve_model cyc=%0d got=%h exp=%h", c, obs, ref_out()); end
      if (m_valid_o && m_ready_i && m_last_o) grants.push_back(int'(m_id_o));
      clk_step();
    end
    total++;
    if (grants.size() != 9) begin bad++; $display("FAIL starve_count got=%0d exp=9", grants.size()); end
    else begin
      for (int k = 0; k < 9; k++) begin
        total++;
        if (grants[k] != exp_g[k]) begin bad++; $display("FAIL starve_grant k=%0d got=%0d exp=%0d", k, grants[k], exp_g[k]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] rx [$];
    logic [DW-1:0] exp_rx [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd64};
    bit dropped = 0;
    do_reset();
    src_set(0, 1, 4, 1); src_set(1, 1, 1, 9);
    hold[1] = 3;
    src_advance('0);
    for (int c = 0; c < 24; c++) begin
      m_ready_i = (c % 3 != 1);
      #2; total++;
      if (obs !== ref_out()) begin bad++; $display("FAIL bp_model cyc=%0d got=%h exp=%h", c, obs, ref_out()); end
      if (m_valid_o && m_ready_i) rx.push_back(m_data_o);
      clk_step();
      if (rx.size() == 2 && !dropped) begin
        s_valid_i[0] = 1'b0; hold[0] = 1; dropped = 1;
      end
    end
    total++;
    if (rx.size() != 5) begin bad++; $display("FAIL bp_beats got=%0d exp=5", rx.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (rx[k] !== exp_rx[k]) begin bad++; $display("FAIL bp_data k=%0d got=%0d exp=%0d", k, rx[k], exp_rx[k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int first_id = -1;
    do_reset();
    m_ready_i = 1'b1;
    src_set(0, 7, 1, 15); src_set(1, 1, 1, 0);
    src_advance('0);
    for (int c = 0; c < 14; c++) begin
      #2; total++;
      if (obs !== ref_out()) begin bad++; $display("FAIL rm_age_model cyc=%0d got=%h exp=%h", c, obs, ref_out()); end
      clk_step();
    end
    // s1 is now at maximum age; park it and start a 4-beat packet on s0.
    s_valid_i[1] = 1'b0; hold[1] = 1000;
    src_set(0, 1, 4, 15);
    src_advance('0);
    for (int c = 0; c < 2; c++) begin
      #2; total++;
      if (obs !== ref_out()) begin bad++; $display("FAIL rm_burst cyc=%0d got=%h exp=%h", c, obs, ref_out()); end
      clk_step();
    end
    #2; total++;
    if (obs !== ref_out() || m_valid_o !== 1'b1) begin bad++; $display("FAIL rm_beat2 got=%h exp=%h", obs, ref_out()); end
    #1 rst_n = 1'b0;
    #1; total++;
    if (obs !== '0) begin bad++; $display("FAIL rm_async got=%h exp=0", obs); end
    ref_reset();
    src_set(0, 1, 1, 15); src_set(1, 1, 1, 0);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1 src_advance('0);
    for (int c = 0; c < 4; c++) begin
      #2; total++;
      if (obs !== ref_out()) begin bad++; $display("FAIL rm_after cyc=%0d got=%h exp=%h", c, obs, ref_out()); end
      if (m_valid_o && first_id < 0) first_id = int'(m_id_o);
      clk_step();
    end
    total++;
    if (first_id != 0) begin bad++; $display("FAIL rm_first_grant got=%0d exp=0", first_id); end
  endtask

  task automatic test_idle_single();
    int nx = 0, xid = -1;
    do_reset();
    m_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #2; total++;
      if (obs !== ref_out()) begin bad++; $display("FAIL idle cyc=%0d got=%h exp=%h", c, obs, ref_out()); end
      clk_step();
    end
    src_set(1, 1, 1, 4);
    src_advance('0);
    for (int c = 0; c < 4; c++) begin
      #2; total++;
      if (obs !== ref_out()) begin bad++; $display("FAIL single cyc=%0d got=%h exp=%h", c, obs, ref_out()); end
      if (m_valid_o && m_ready_i) begin nx++; xid = int'(m_id_o); end
      clk_step();
    end
    total++;
    if (nx != 1 || xid != 1) begin bad++; $display("FAIL single_xfer got n=%0d id=%0d exp n=1 id=1", nx, xid); end
  endtask

  task automatic test_random();
    do_reset();
    rnd = 1;
    src_advance('0);
    for (int c = 0; c < 3000; c++) begin
      m_ready_i = ($urandom_range(0, 3) != 0);
      #2; total++;
      if (obs !== ref_out()) begin bad++; $display("FAIL rand cyc=%0d got=%h exp=%h", c, obs, ref_out()); end
      clk_step();
    end
  endtask

  initial begin
    rnd = 0;
    m_ready_i = 1'b0;
    s_valid_i = '0;
    s_last_i  = '0;
    for (int i = 0; i < NS; i++) begin
      s_data_i[i] = '0; s_qos_i[i] = '0;
    end
    test_reset();
    test_priority();
    test_round_robin();
    test_starvation();
    test_backpressure();
    test_reset_mid();
    test_idle_single();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
